// File: rtl/apb_interconnect_wd.sv
// apb_interconnect_wd: APB decoder/mux from one bridge master port to NUM_SLV slots,
// completing unmapped and hung accesses with PSLVERR and keeping sticky error status.
module apb_interconnect_wd #(
  parameter int          NUM_SLV     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          REGION_BITS = 12,
  parameter int          TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m_psel,
  input  logic                 m_penable,
  input  logic                 m_pwrite,
  input  logic [31:0]          m_paddr,
  input  logic [31:0]          m_pwdata,
  output logic [31:0]          m_prdata,
  output logic                 m_pready,
  output logic                 m_pslverr,
  output logic [NUM_SLV-1:0]   s_psel,
  output logic                 s_penable,
  output logic                 s_pwrite,
  output logic [31:0]          s_paddr,
  output logic [31:0]          s_pwdata,
  input  logic [32*NUM_SLV-1:0] s_prdata,
  input  logic [NUM_SLV-1:0]   s_pready,
  input  logic [NUM_SLV-1:0]   s_pslverr,
  input  logic                 err_clr,
  output logic                 err_valid,
  output logic [1:0]           err_code,
  output logic [31:0]          err_addr
);
  localparam int IW = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
  localparam int CW = $clog2(TIMEOUT + 1) > 8 ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [32:0] SPAN = 33'(NUM_SLV) << REGION_BITS;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic hit, hit_q, abort, act, dec_err, tmo;
  logic [31:0] off;
  logic [IW-1:0] idx, idx_q;
  logic [CW-1:0] wcnt;
  assign off = m_paddr - BASE_ADDR;
  assign hit = (m_paddr >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign idx = IW'(off >> REGION_BITS);
  assign abort = wcnt == CW'(TIMEOUT);
  // Responses are only ever returned while the FSM is in ACCESS with PENABLE high
  assign act = rst_n && state == ACCESS && m_penable;
  assign m_pready = act && (abort || !hit_q || s_pready[idx_q]);
  assign m_pslverr = act && (abort || !hit_q || s_pslverr[idx_q]);
  assign m_prdata = (act && hit_q && !abort) ? s_prdata[32*idx_q +: 32] : '0;
  assign dec_err = act && !hit_q;
  assign tmo = act && hit_q && abort;
  assign s_psel = (rst_n && m_psel && (state == IDLE ? hit : hit_q && !abort))
                  ? NUM_SLV'(1) << (state == IDLE ? idx : idx_q) : '0;
  assign s_penable = rst_n && m_penable && !abort;
  assign s_pwrite = rst_n && m_pwrite;
  assign s_paddr = rst_n ? m_paddr : '0;
  assign s_pwdata = rst_n ? m_pwdata : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hit_q <= 1'b0;
      idx_q <= '0;
      wcnt <= '0;
      err_valid <= 1'b0;
      err_code <= 2'b00;
      err_addr <= '0;
    end else begin
      case (state)
        IDLE: if (m_psel) begin
          hit_q <= hit;
          idx_q <= idx;
          state <= m_penable ? ACCESS : SETUP;
        end
        SETUP: state <= !m_psel ? IDLE : m_penable ? ACCESS : SETUP;
        ACCESS: if (m_pready || !m_psel) state <= IDLE;
        default: state <= IDLE;
      endcase
      wcnt <= (state == ACCESS && m_psel && !m_pready)
              ? wcnt + CW'(m_penable && !s_pready[idx_q]) : '0;
      if (dec_err || tmo) begin
        err_valid <= 1'b1;
        err_code <= dec_err ? 2'b01 : 2'b10;
        err_addr <= m_paddr;
      end else if (err_clr) begin
        err_valid <= 1'b0;
        err_code <= 2'b00;
        err_addr <= '0;
      end
    end
  end
endmodule
